seq_bit_serializer: RTL and testbench
=====================================

# seq_bit_serializer

Upstream feeder for the sequence-detector stage. It accepts parallel bit patterns over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single serial line that drives the detector's data input. A one-entry holding register lets the next pattern be queued while the current one shifts, so consecutive patterns stream with no idle gap.

## Interface
- WIDTH, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(WIDTH+1): width of the length field.

- clk  in  1  rising-edge clock, shared with the detector.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  a pattern is offered on load_data/load_len.
- load_ready  out  1  serializer can accept a pattern this cycle.
- load_data  in  WIDTH  pattern; the low load_len bits are used.
- load_len  in  LEN_W  number of bits to send; 0 is treated as WIDTH; values >WIDTH are clamped to WIDTH.
- bit_out  out  1  serial data to the detector (registered).
- bit_valid  out  1  bit_out carries a pattern bit this cycle.
- last  out  1  bit_out is the final bit of the current pattern.
- busy  out  1  shifter active or holding register occupied.

## Operation
- Two storage elements: shifter (data, remaining count) and holding register (data, len, full flag).
- States: IDLE (shifter empty) and SHIFT (shifter presenting a bit).
- Handshake: transfer occurs on an edge where load_valid && load_ready; load_data/load_len must be held stable by the source until transfer; load_ready = !hold_full && !rst.
- Shifter becomes free at an edge when in IDLE, or in SHIFT with last=1.
- At each edge: if the shifter becomes free, it loads the holding register if full (holding empties), else the transferring word if any, else goes to IDLE. A transferring word not taken by the shifter goes into the holding register.
- Bit order: for length L, sends data[L-1] first, data[0] last.
- IDLE outputs: bit_out=0, bit_valid=0, last=0.
- busy = (state==SHIFT) || hold_full.

## Timing
- Reset: on an edge with rst=1, state=IDLE, hold_full=0, bit_out=0, bit_valid=0, last=0, busy=0; load_ready=0 while rst is high, 1 the cycle after. Reset mid-pattern discards shifter and holding contents; no further bits are emitted.
- Latency: word transferred at edge k while IDLE → first bit on bit_out from edge k through edge k+1; L bits occupy L consecutive cycles; last high in the L-th cycle.
- Back-to-back: if the next word is held or transferred at the edge ending the last bit, its first bit appears the very next cycle (bit_valid stays high, no gap).
- Simultaneous: holding full and shifter finishing → holding moves to shifter; load_ready was 0, so no new transfer that edge; load_ready returns to 1 the next cycle.
- L=1: last=1 in the single cycle the bit is shown.
- Throughput: one bit per clock sustained; the holding register refills while a pattern of L≥2 shifts.

## Structure
- Shared package seq_pkg: state enum (IDLE, SHIFT), WIDTH default constant, and the len-normalise function (0→WIDTH, clamp).
- One natural sub-module: seq_hold_reg (single-entry buffer: data, len, full; push/pop ports); the shifter and FSM stay in the top module.

## Test plan
- Reset: hold rst 3 cycles with load_valid=1 → load_ready=0, bit_out=0, bit_valid=0, busy=0 throughout; first transfer on the first edge after rst falls.
- Single pattern: load_data=8'b10011100, len=8 → bit_out 1,0,0,1,1,1,0,0 on 8 consecutive cycles, bit_valid high 8 cycles, last only in cycle 8, then IDLE with bit_out=0.
- Back-to-back: send 8'hA5 (len 8), then immediately 4'b0110 (len 4) → 12 contiguous valid bits 1010010 1 0110, last in cycles 8 and 12, load_ready drops while the second word waits, no gap.
- Length edges: len=1 data=1 → one valid bit 1 with last=1; len=0 data=8'hFF → 8 ones; len=9 with WIDTH=8 → treated as 8.
- Backpressure: keep load_valid high with three words 8'h81, 8'h42, 8'h24 → third word accepted only when the first finishes; output 24 contiguous bits in order, no word lost or duplicated.
- Reset mid-operation: assert rst during bit 4 of 8'hF0 with a word held → bit_valid=0 next cycle, busy=0, held word never appears.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector feeder: FSM states,
// default pattern width and the pattern-length normalisation rule.
package seq_pkg;

    // Default maximum pattern length in bits.
    localparam int SEQ_WIDTH = 8;

    // IDLE: shifter empty. SHIFT: shifter presenting a pattern bit.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A length of 0 means a full-width pattern; oversize lengths clamp to width.
    function automatic int norm_len(input int len, input int width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_hold_reg.sv
// Single-entry holding buffer that queues the next pattern while the
// current one shifts. Push and pop never coincide: a push only happens
// when the entry is empty, a pop only when it is full.
module seq_hold_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic [LEN_W-1:0] push_len,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic [LEN_W-1:0] len
);

    // Capture a pattern on push, release it on pop; reset empties the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
            len  <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
            len  <= push_len;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Patterns arrive over
// a valid/ready handshake and leave MSB-first, one bit per clock. A one-entry
// holding register lets the next pattern queue up so patterns stream
// back-to-back without idle cycles.
//
// Handshake: a pattern transfers on a rising edge where load_valid and
// load_ready are both high; the source holds load_data/load_len stable until
// then. load_ready is high whenever the holding register is empty and reset
// is not asserted, independent of load_valid.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_data, sh_data_nxt;   // remaining bits, left-justified
    logic [LEN_W-1:0] sh_rem, sh_rem_nxt;     // bits still to show after the current one
    logic             bit_q, bit_nxt;
    logic             valid_q, valid_nxt;
    logic             last_q, last_nxt;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [LEN_W-1:0] hold_len;
    logic             hold_push, hold_pop;

    logic             xfer;
    logic             shifter_free;
    logic [LEN_W-1:0] in_len;
    logic             ld_take;
    logic [WIDTH-1:0] ld_data;
    logic [LEN_W-1:0] ld_len;
    logic [WIDTH-1:0] aligned;

    assign in_len       = LEN_W'(norm_len(int'(load_len), WIDTH));
    assign load_ready   = !hold_full && !rst;
    assign xfer         = load_valid && load_ready;
    // The shifter can take a new pattern when empty or when showing its final bit.
    assign shifter_free = (state == IDLE) || last_q;

    // The held pattern is older than any incoming one, so it always wins.
    assign ld_take   = hold_full || xfer;
    assign ld_data   = hold_full ? hold_data : load_data;
    assign ld_len    = hold_full ? hold_len  : in_len;
    assign hold_pop  = shifter_free && hold_full;
    assign hold_push = xfer && !shifter_free;

    seq_hold_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .push      (hold_push),
        .push_data (load_data),
        .push_len  (in_len),
        .pop       (hold_pop),
        .full      (hold_full),
        .data      (hold_data),
        .len       (hold_len)
    );

    // Next-state and next-output logic for the shifter FSM.
    always_comb begin
        state_nxt   = state;
        sh_data_nxt = sh_data;
        sh_rem_nxt  = sh_rem;
        bit_nxt     = bit_q;
        valid_nxt   = valid_q;
        last_nxt    = last_q;
        aligned     = '0;
        if (shifter_free) begin
            if (ld_take) begin
                // Left-justify so the pattern MSB (bit len-1) lands on the top bit.
                aligned     = ld_data << (LEN_W'(WIDTH) - ld_len);
                state_nxt   = SHIFT;
                bit_nxt     = aligned[WIDTH-1];
                sh_data_nxt = aligned << 1;
                sh_rem_nxt  = ld_len - LEN_W'(1);
                valid_nxt   = 1'b1;
                last_nxt    = (ld_len == LEN_W'(1));
            end else begin
                state_nxt   = IDLE;
                sh_data_nxt = '0;
                sh_rem_nxt  = '0;
                bit_nxt     = 1'b0;
                valid_nxt   = 1'b0;
                last_nxt    = 1'b0;
            end
        end else begin
            bit_nxt     = sh_data[WIDTH-1];
            sh_data_nxt = sh_data << 1;
            sh_rem_nxt  = sh_rem - LEN_W'(1);
            valid_nxt   = 1'b1;
            last_nxt    = (sh_rem == LEN_W'(1));
        end
    end

    // State and registered serial outputs; reset discards any pattern in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh_data <= '0;
            sh_rem  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sh_data <= sh_data_nxt;
            sh_rem  <= sh_rem_nxt;
            bit_q   <= bit_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign last      = last_q;
    assign busy      = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer. The reference model is a queue of expected
// serial bits: every accepted pattern appends its bits in send order and
// every clock shows and consumes the head. Ready is derived from whether any
// accepted pattern has not started showing yet.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             bit_out;
    logic             bit_valid;
    logic             last;
    logic             busy;

    seq_bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .last       (last),
        .busy       (busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Model state: {first, last, bit} per expected serial bit.
    logic [2:0]             exp_q[$];
    logic [LEN_W+WIDTH-1:0] src_q[$];   // {len, data} words waiting to be offered
    logic [1:0]             cap_q[$];   // {last, bit} captured while bit_valid
    int                     n_tests = 0;
    int                     n_fail  = 0;
    logic                   presenting;
    logic                   gap_en;
    logic                   xfer_seen;
    logic [4:0]             obs, expv;   // {load_ready, busy, bit_valid, bit_out, last}

    // Patterns accepted whose first bit is not on the line yet.
    function automatic int unshown();
        int c = 0;
        for (int i = 1; i < exp_q.size(); i++) if (exp_q[i][2]) c++;
        return c;
    endfunction

    task automatic model_push(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        int n;
        n = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back({i == n - 1, i == 0, d[i]});
    endtask

    // Driver: offer the next source word, clock once, advance the model, sample at negedge.
    task automatic run_cycle();
        if (!presenting && src_q.size() > 0 && (!gap_en || $urandom_range(3, 0) != 0))
            presenting = 1'b1;
        if (presenting) begin
            load_valid = 1'b1;
            {load_len, load_data} = src_q[0];
        end else begin
            load_valid = 1'b0;
            load_data  = WIDTH'($urandom);
            load_len   = LEN_W'($urandom);
        end
        @(posedge clk);
        xfer_seen = load_valid && !rst && (unshown() == 0);
        if (rst) exp_q.delete();
        else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (xfer_seen) model_push(load_data, load_len);
        end
        if (xfer_seen) begin
            void'(src_q.pop_front());
            presenting = 1'b0;
        end
        @(negedge clk);
        obs = {load_ready, busy, bit_valid, bit_out, last};
        if (exp_q.size() > 0) expv = {!rst && unshown() == 0, 1'b1, 1'b1, exp_q[0][0], exp_q[0][1]};
        else                  expv = {!rst, 4'b0000};
        if (bit_valid) cap_q.push_back({last, bit_out});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_q.push_back({4'd8, 8'h3C});
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            n_tests++;
            if (obs !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=00000", c, obs);
            end
        end
        rst = 1'b0;
        run_cycle();
        n_tests++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b0 || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_first_xfer got valid=%b bit=%b exp valid=1 bit=0", bit_valid, bit_out);
        end
        for (int c = 0; c < 40 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_drain cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] bits, lasts;
        cap_q.delete();
        src_q.push_back({4'd8, 8'b10011100});
        for (int c = 0; c < 40 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        bits = '0; lasts = '0;
        for (int i = 0; i < cap_q.size(); i++) begin
            bits  = {bits[6:0], cap_q[i][0]};
            lasts = {lasts[6:0], cap_q[i][1]};
        end
        n_tests++;
        if (cap_q.size() != 8 || bits !== 8'b10011100 || lasts !== 8'b00000001) begin
            n_fail++;
            $display("FAIL single_stream got n=%0d bits=%b last=%b exp n=8 bits=10011100 last=00000001",
                     cap_q.size(), bits, lasts);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits, lasts;
        cap_q.delete();
        src_q.push_back({4'd8, 8'hA5});
        src_q.push_back({4'd4, 8'h06});
        for (int c = 0; c < 40 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        bits = '0; lasts = '0;
        for (int i = 0; i < cap_q.size(); i++) begin
            bits  = {bits[10:0], cap_q[i][0]};
            lasts = {lasts[10:0], cap_q[i][1]};
        end
        n_tests++;
        if (cap_q.size() != 12 || bits !== 12'b1010_0101_0110 || lasts !== 12'b0000_0001_0001) begin
            n_fail++;
            $display("FAIL b2b_stream got n=%0d bits=%b last=%b exp n=12 bits=101001010110 last=000000010001",
                     cap_q.size(), bits, lasts);
        end
    endtask

    task automatic test_length_edges();
        logic [16:0] bits, lasts;
        cap_q.delete();
        src_q.push_back({4'd1, 8'h01});
        src_q.push_back({4'd0, 8'hFF});
        src_q.push_back({4'd9, 8'h5A});
        for (int c = 0; c < 60 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL len_edges cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        bits = '0; lasts = '0;
        for (int i = 0; i < cap_q.size(); i++) begin
            bits  = {bits[15:0], cap_q[i][0]};
            lasts = {lasts[15:0], cap_q[i][1]};
        end
        n_tests++;
        if (cap_q.size() != 17 || bits !== 17'b1_11111111_01011010 || lasts !== 17'b1_00000001_00000001) begin
            n_fail++;
            $display("FAIL len_stream got n=%0d bits=%b last=%b exp n=17", cap_q.size(), bits, lasts);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] bits, lasts;
        int          acc_cyc;
        cap_q.delete();
        acc_cyc = -1;
        src_q.push_back({4'd8, 8'h81});
        src_q.push_back({4'd8, 8'h42});
        src_q.push_back({4'd8, 8'h24});
        for (int c = 1; c < 80 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            run_cycle();
            if (xfer_seen && src_q.size() == 0 && acc_cyc < 0) acc_cyc = c;
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL backpressure cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        n_tests++;
        if (acc_cyc != 10) begin
            n_fail++;
            $display("FAIL third_accept got edge=%0d exp edge=10", acc_cyc);
        end
        bits = '0; lasts = '0;
        for (int i = 0; i < cap_q.size(); i++) begin
            bits  = {bits[22:0], cap_q[i][0]};
            lasts = {lasts[22:0], cap_q[i][1]};
        end
        n_tests++;
        if (cap_q.size() != 24 || bits !== 24'h814224 || lasts !== 24'h010101) begin
            n_fail++;
            $display("FAIL bp_stream got n=%0d bits=%h last=%h exp n=24 bits=814224 last=010101",
                     cap_q.size(), bits, lasts);
        end
    endtask

    task automatic test_reset_mid();
        cap_q.delete();
        src_q.push_back({4'd8, 8'hF0});
        src_q.push_back({4'd8, 8'h3C});
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        rst = 1'b1;
        run_cycle();
        n_tests++;
        if (bit_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear got valid=%b busy=%b ready=%b exp 0 0 0", bit_valid, busy, load_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        n_tests++;
        if (cap_q.size() != 4 || cap_q[0][0] !== 1'b1 || cap_q[3][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_stream got n=%0d exp n=4 of ones", cap_q.size());
        end
    endtask

    task automatic test_random();
        int total;
        cap_q.delete();
        gap_en = 1'b1;
        total = 0;
        for (int w = 0; w < 30; w++) begin
            logic [LEN_W-1:0] l;
            l = LEN_W'($urandom_range(15, 0));
            total += norm_len(int'(l), WIDTH);
            src_q.push_back({l, WIDTH'($urandom)});
        end
        for (int c = 0; c < 2000 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            run_cycle();
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, obs, expv);
            end
        end
        n_tests++;
        if (cap_q.size() != total || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_count got bits=%0d exp bits=%0d", cap_q.size(), total);
        end
        gap_en = 1'b0;
    endtask

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        presenting = 1'b0;
        gap_en     = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_length_edges();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
